// File: rtl/npu_pkg.sv
// Shared NPU constants, requantizer FSM state type and bit-exact saturating helpers.
package npu_pkg;

  localparam int DATA_W  = 8;
  localparam int ACC_W   = 32;
  localparam int ARRAY_N = 16;
  localparam int PROD_W  = ACC_W + 9;   // INT32 sum times a 9-bit non-negative scale
  localparam int RND_W   = PROD_W + 1;  // headroom for the rounding increment

  typedef enum logic [1:0] {
    RQ_IDLE  = 2'd0,
    RQ_RUN   = 2'd1,
    RQ_DRAIN = 2'd2,
    RQ_DONE  = 2'd3
  } requant_state_t;

  function automatic logic signed [ACC_W-1:0] sat_add_i32(
    input logic signed [ACC_W-1:0] a,
    input logic signed [ACC_W-1:0] b
  );
    logic signed [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (s[ACC_W] != s[ACC_W-1])
      return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    return s[ACC_W-1:0];
  endfunction

  // In range exactly when every bit from the INT8 sign bit upward agrees.
  function automatic logic fits_i8(input logic signed [RND_W-1:0] v);
    return (&v[RND_W-1:DATA_W-1]) || !(|v[RND_W-1:DATA_W-1]);
  endfunction

  function automatic logic [DATA_W-1:0] saturate_i8(input logic signed [RND_W-1:0] v);
    if (fits_i8(v))
      return v[DATA_W-1:0];
    return v[RND_W-1] ? 8'h80 : 8'h7F;
  endfunction

endpackage

// File: rtl/requant_lane.sv
// One lane of the requantizer: bias add (S1), scale multiply (S2), round/shift/saturate (S3).
module requant_lane
  import npu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              soft_rst,
  input  logic              en1,
  input  logic              en2,
  input  logic              en3,
  input  logic [7:0]        scale,
  input  logic [4:0]        shift,
  input  logic [ACC_W-1:0]  acc,
  input  logic [ACC_W-1:0]  bias,
  output logic [DATA_W-1:0] q8,
  output logic              sat
);

  logic signed [ACC_W-1:0]  sum_reg;
  logic signed [PROD_W-1:0] prod_reg;
  logic signed [PROD_W-1:0] prod_next;
  logic        [RND_W-1:0]  half;
  logic signed [RND_W-1:0]  rnd;
  logic signed [RND_W-1:0]  q;

  assign prod_next = PROD_W'(sum_reg) * PROD_W'($signed({1'b0, scale}));
  assign half      = (shift == 5'd0) ? '0 : (RND_W'(1) << (shift - 5'd1));
  assign rnd       = $signed({prod_reg[PROD_W-1], prod_reg} + half);
  assign q         = rnd >>> shift;
  // Flag is combinational off S2 so the top can count it on the same edge S3 loads.
  assign sat       = !fits_i8(q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_reg  <= '0;
      prod_reg <= '0;
      q8       <= '0;
    end else if (soft_rst) begin
      sum_reg  <= '0;
      prod_reg <= '0;
      q8       <= '0;
    end else begin
      if (en1) sum_reg  <= sat_add_i32($signed(acc), $signed(bias));
      if (en2) prod_reg <= prod_next;
      if (en3) q8       <= saturate_i8(q);
    end
  end

endmodule

// File: rtl/gemm_requant_pipe.sv
// Requantization pipeline after the systolic array drain: INT32 rows in, INT8 rows out,
// one job of cfg_rows beats per cfg_start, with saturation counting.
module gemm_requant_pipe #(
  parameter int LANES  = npu_pkg::ARRAY_N,
  parameter int ACC_W  = npu_pkg::ACC_W,
  parameter int OUT_W  = npu_pkg::DATA_W,
  parameter int ROWS_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   soft_rst,
  input  logic                   cfg_start,
  input  logic [ROWS_W-1:0]      cfg_rows,
  input  logic [7:0]             cfg_scale,
  input  logic [7:0]             cfg_shift,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            sat_count,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*ACC_W-1:0] in_acc,
  input  logic [LANES*ACC_W-1:0] in_bias,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_data,
  output logic                   out_last
);
  import npu_pkg::*;

  localparam int POP_W = $clog2(LANES + 1);

  requant_state_t    state_reg;
  logic [ROWS_W-1:0] rows_reg;
  logic [ROWS_W-1:0] rows_m1;
  logic [7:0]        scale_reg;
  logic [4:0]        shift_reg;
  logic [ROWS_W-1:0] in_cnt_reg;
  logic [ROWS_W-1:0] out_cnt_reg;
  logic [15:0]       sat_count_reg;
  logic              v1_reg, v2_reg, v3_reg;
  logic              load1, load2, load3;
  logic              in_fire, out_fire, en3;
  logic [LANES-1:0]  sat_flags;
  logic [POP_W-1:0]  sat_pop;
  logic [16:0]       sat_sum;

  // A stage may load when it is empty or its contents move on this cycle.
  assign load3    = !v3_reg || out_ready;
  assign load2    = !v2_reg || load3;
  assign load1    = !v1_reg || load2;
  assign in_ready = (state_reg == RQ_RUN) && (in_cnt_reg < rows_reg) && load1;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = v3_reg && out_ready;
  assign en3      = load3 && v2_reg;
  assign rows_m1  = rows_reg - ROWS_W'(1);

  assign busy      = (state_reg != RQ_IDLE);
  assign done      = (state_reg == RQ_DONE);
  assign sat_count = sat_count_reg;
  assign out_valid = v3_reg;
  assign out_last  = v3_reg && (out_cnt_reg == rows_m1);

  always_comb begin
    sat_pop = '0;
    for (int i = 0; i < LANES; i++)
      sat_pop = sat_pop + POP_W'(sat_flags[i]);
  end
  assign sat_sum = {1'b0, sat_count_reg} + 17'(sat_pop);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    requant_lane u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .soft_rst (soft_rst),
      .en1      (in_fire),
      .en2      (load2 && v1_reg),
      .en3      (en3),
      .scale    (scale_reg),
      .shift    (shift_reg),
      .acc      (in_acc[gi*ACC_W +: ACC_W]),
      .bias     (in_bias[gi*ACC_W +: ACC_W]),
      .q8       (out_data[gi*OUT_W +: OUT_W]),
      .sat      (sat_flags[gi])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= RQ_IDLE;
      rows_reg      <= '0;
      scale_reg     <= '0;
      shift_reg     <= '0;
      in_cnt_reg    <= '0;
      out_cnt_reg   <= '0;
      sat_count_reg <= '0;
      v1_reg        <= 1'b0;
      v2_reg        <= 1'b0;
      v3_reg        <= 1'b0;
    end else if (soft_rst) begin
      state_reg     <= RQ_IDLE;
      rows_reg      <= '0;
      scale_reg     <= '0;
      shift_reg     <= '0;
      in_cnt_reg    <= '0;
      out_cnt_reg   <= '0;
      sat_count_reg <= '0;
      v1_reg        <= 1'b0;
      v2_reg        <= 1'b0;
      v3_reg        <= 1'b0;
    end else begin
      if (load1)    v1_reg      <= in_fire;
      if (load2)    v2_reg      <= v1_reg;
      if (load3)    v3_reg      <= v2_reg;
      if (in_fire)  in_cnt_reg  <= in_cnt_reg + ROWS_W'(1);
      if (out_fire) out_cnt_reg <= out_cnt_reg + ROWS_W'(1);
      if (en3)      sat_count_reg <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];

      case (state_reg)
        RQ_IDLE: if (cfg_start) begin
          rows_reg      <= cfg_rows;
          scale_reg     <= cfg_scale;
          shift_reg     <= (cfg_shift > 8'd31) ? 5'd31 : cfg_shift[4:0];
          in_cnt_reg    <= '0;
          out_cnt_reg   <= '0;
          sat_count_reg <= '0;
          state_reg     <= (cfg_rows == '0) ? RQ_DONE : RQ_RUN;
        end
        RQ_RUN:   if (in_fire && (in_cnt_reg == rows_m1)) state_reg <= RQ_DRAIN;
        RQ_DRAIN: if (out_fire && (out_cnt_reg == rows_m1)) state_reg <= RQ_DONE;
        RQ_DONE:  state_reg <= RQ_IDLE;
        default:  state_reg <= RQ_IDLE;
      endcase
    end
  end

endmodule
